// File: rtl/msg_unit_load_sequencer_pkg.sv
// Shared definitions for the message load sequencer: FSM state encoding,
// default frame geometry and the slot counter width helper.
package msg_unit_load_sequencer_pkg;

    localparam int DEFAULT_UNIT_NUM   = 3;
    localparam int DEFAULT_UNIT_WIDTH = 4;

    typedef enum logic [1:0] {
        ST_FILL  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FULL  = 2'd2
    } seq_state_e;

    // Width of a counter that must reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/msg_unit_load_sequencer_unit_slot_pointer.sv
// Modulo-UNIT_NUM slot counter with a one-hot decode of the current slot,
// used to steer each accepted message into the next combiner slot.
module msg_unit_load_sequencer_unit_slot_pointer
    import msg_unit_load_sequencer_pkg::*;
#(
    parameter int UNIT_NUM = DEFAULT_UNIT_NUM,
    parameter int CNT_W    = cnt_width(UNIT_NUM)
) (
    input  logic                sys_clk,
    input  logic                rst,
    input  logic                inc,
    input  logic                clr,
    output logic [CNT_W-1:0]    cnt,
    output logic [UNIT_NUM-1:0] onehot
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = (cnt_q == CNT_W'(UNIT_NUM - 1)) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        onehot = '0;
        for (int i = 0; i < UNIT_NUM; i++) begin
            onehot[i] = (cnt_q == CNT_W'(i));
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/msg_unit_load_sequencer.sv
// Feeds a data bus combiner one narrow message per slot, flags a complete
// frame and stalls the producer until the consumer acknowledges the bus.
module msg_unit_load_sequencer
    import msg_unit_load_sequencer_pkg::*;
#(
    parameter int  UNIT_NUM   = DEFAULT_UNIT_NUM,
    parameter int  UNIT_WIDTH = DEFAULT_UNIT_WIDTH,
    localparam int CNT_W      = cnt_width(UNIT_NUM)
) (
    input  logic                           sys_clk,
    input  logic                           rst,
    input  logic [UNIT_WIDTH-1:0]          msg_i,
    input  logic                           msg_valid_i,
    output logic                           msg_ready_o,
    input  logic                           flush_i,
    input  logic                           bus_ack_i,
    output logic [UNIT_NUM*UNIT_WIDTH-1:0] load_data_o,
    output logic [UNIT_NUM-1:0]            load_en_o,
    output logic                           bus_valid_o,
    output logic [CNT_W-1:0]               slot_cnt_o
);

    seq_state_e state_q;
    seq_state_e state_d;

    logic                           accept;
    logic [CNT_W-1:0]               slot_cnt;
    logic [UNIT_NUM-1:0]            slot_onehot;
    logic                           slot_last;

    logic [UNIT_NUM-1:0]            load_en_q;
    logic [UNIT_NUM-1:0]            load_en_d;
    logic [UNIT_NUM*UNIT_WIDTH-1:0] load_data_q;
    logic [UNIT_NUM*UNIT_WIDTH-1:0] load_data_d;
    logic                           bus_valid_q;
    logic                           bus_valid_d;

    msg_unit_load_sequencer_unit_slot_pointer #(
        .UNIT_NUM (UNIT_NUM),
        .CNT_W    (CNT_W)
    ) u_slot_pointer (
        .sys_clk (sys_clk),
        .rst     (rst),
        .inc     (accept),
        .clr     (flush_i),
        .cnt     (slot_cnt),
        .onehot  (slot_onehot)
    );

    assign slot_last = (slot_cnt == CNT_W'(UNIT_NUM - 1));

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            state_q <= ST_FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // DRAIN gives the combiner one cycle to latch the final slot before FULL.
    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_FILL;
        end else begin
            case (state_q)
                ST_FILL:  if (accept && slot_last) state_d = ST_DRAIN;
                ST_DRAIN: state_d = ST_FULL;
                ST_FULL:  if (bus_ack_i) state_d = ST_FILL;
                default:  state_d = ST_FILL;
            endcase
        end
    end

    always_comb begin
        msg_ready_o = (state_q == ST_FILL) && !flush_i && !rst;
        accept      = msg_valid_i && msg_ready_o;
    end

    always_comb begin
        load_en_d   = accept ? slot_onehot : '0;
        load_data_d = accept ? {UNIT_NUM{msg_i}} : load_data_q;
        bus_valid_d = (state_d == ST_FULL);
    end

    always_ff @(posedge sys_clk) begin
        if (rst) begin
            load_en_q   <= '0;
            load_data_q <= '0;
            bus_valid_q <= 1'b0;
        end else begin
            load_en_q   <= load_en_d;
            load_data_q <= load_data_d;
            bus_valid_q <= bus_valid_d;
        end
    end

    assign load_en_o   = load_en_q;
    assign load_data_o = load_data_q;
    assign bus_valid_o = bus_valid_q;
    assign slot_cnt_o  = slot_cnt;

endmodule

// File: tb/tb_msg_unit_load_sequencer.sv
// Self-checking bench: directed frames plus random traffic against a
// frame-level reference model, with a behavioural combiner downstream.
module tb_msg_unit_load_sequencer;

    localparam int UNIT_NUM   = 3;
    localparam int UNIT_WIDTH = 4;
    localparam int CNT_W      = 2;
    localparam int BUS_W      = UNIT_NUM * UNIT_WIDTH;

    logic                   sys_clk = 1'b0;
    logic                   rst;
    logic [UNIT_WIDTH-1:0]  msg_i;
    logic                   msg_valid_i;
    logic                   msg_ready_o;
    logic                   flush_i;
    logic                   bus_ack_i;
    logic [BUS_W-1:0]       load_data_o;
    logic [UNIT_NUM-1:0]    load_en_o;
    logic                   bus_valid_o;
    logic [CNT_W-1:0]       slot_cnt_o;

    always #5 sys_clk = ~sys_clk;

    msg_unit_load_sequencer #(
        .UNIT_NUM   (UNIT_NUM),
        .UNIT_WIDTH (UNIT_WIDTH)
    ) dut (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .msg_i       (msg_i),
        .msg_valid_i (msg_valid_i),
        .msg_ready_o (msg_ready_o),
        .flush_i     (flush_i),
        .bus_ack_i   (bus_ack_i),
        .load_data_o (load_data_o),
        .load_en_o   (load_en_o),
        .bus_valid_o (bus_valid_o),
        .slot_cnt_o  (slot_cnt_o)
    );

    // Downstream combiner: each slot latches its lane when its load enable is set.
    logic [UNIT_WIDTH-1:0] comb_slot [UNIT_NUM];
    logic [BUS_W-1:0]      port_out;

    always_ff @(posedge sys_clk) begin
        for (int i = 0; i < UNIT_NUM; i++) begin
            if (load_en_o[i]) comb_slot[i] <= load_data_o[i*UNIT_WIDTH +: UNIT_WIDTH];
        end
    end

    always_comb begin
        port_out = '0;
        for (int i = 0; i < UNIT_NUM; i++) begin
            port_out[i*UNIT_WIDTH +: UNIT_WIDTH] = comb_slot[i];
        end
    end

    int                    fill_cnt;
    bit                    frame_done;
    int                    done_age;
    logic [UNIT_NUM-1:0]   exp_load_en;
    logic [BUS_W-1:0]      exp_load_data;
    logic                  exp_bus_valid;
    logic [UNIT_WIDTH-1:0] frame_msgs [UNIT_NUM];

    int check_count = 0;
    int error_count = 0;

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic modelReset();
        fill_cnt      = 0;
        frame_done    = 1'b0;
        done_age      = 0;
        exp_load_en   = '0;
        exp_load_data = '0;
        exp_bus_valid = 1'b0;
    endtask

    task automatic checkCycle();
        logic             exp_ready;
        logic [BUS_W-1:0] exp_frame;
        exp_ready = !rst && !flush_i && !frame_done;
        checkOutput("msg_ready", 32'(msg_ready_o), 32'(exp_ready));
        checkOutput("load_en", 32'(load_en_o), 32'(exp_load_en));
        checkOutput("load_data", 32'(load_data_o), 32'(exp_load_data));
        checkOutput("bus_valid", 32'(bus_valid_o), 32'(exp_bus_valid));
        checkOutput("slot_cnt", 32'(slot_cnt_o), frame_done ? 32'd0 : 32'(fill_cnt));
        if (exp_bus_valid) begin
            exp_frame = '0;
            for (int i = 0; i < UNIT_NUM; i++) exp_frame[i*UNIT_WIDTH +: UNIT_WIDTH] = frame_msgs[i];
            checkOutput("port_out", 32'(port_out), 32'(exp_frame));
        end
    endtask

    // Frame-level view: messages fill slots in order, the bus is announced two
    // cycles after the last one, and an ack seen while announced reopens intake.
    task automatic modelStep();
        if (rst) begin
            modelReset();
        end else if (flush_i) begin
            fill_cnt      = 0;
            frame_done    = 1'b0;
            done_age      = 0;
            exp_load_en   = '0;
            exp_bus_valid = 1'b0;
        end else begin
            exp_load_en = '0;
            if (frame_done) begin
                if (exp_bus_valid && bus_ack_i) frame_done = 1'b0;
                else done_age++;
            end else if (msg_valid_i) begin
                exp_load_en = UNIT_NUM'(1) << fill_cnt;
                for (int i = 0; i < UNIT_NUM; i++) exp_load_data[i*UNIT_WIDTH +: UNIT_WIDTH] = msg_i;
                frame_msgs[fill_cnt] = msg_i;
                fill_cnt++;
                if (fill_cnt == UNIT_NUM) begin
                    fill_cnt   = 0;
                    frame_done = 1'b1;
                    done_age   = 0;
                end
            end
            exp_bus_valid = frame_done && (done_age >= 1);
        end
    endtask

    task automatic applyStimulus(input logic r, input logic v, input logic [UNIT_WIDTH-1:0] m,
                                 input logic f, input logic a);
        rst         = r;
        msg_valid_i = v;
        msg_i       = m;
        flush_i     = f;
        bus_ack_i   = a;
        @(negedge sys_clk);
        checkCycle();
        modelStep();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        rst         = 1'b1;
        msg_valid_i = 1'b0;
        msg_i       = '0;
        flush_i     = 1'b0;
        bus_ack_i   = 1'b0;
        modelReset();
        @(posedge sys_clk);
        #1;
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, '0, 1'b0, 1'b0);

        $display("[TB] back-to-back frame");
        applyStimulus(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'hB, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("frame_cba", 32'(port_out), 32'h0CBA);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        $display("[TB] frame with valid gaps");
        applyStimulus(1'b0, 1'b1, 4'hA, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 4'hB, 1'b0, 1'b0);
        idleCycles(2);
        applyStimulus(1'b0, 1'b1, 4'hC, 1'b0, 1'b0);
        idleCycles(2);
        checkOutput("gap_frame_cba", 32'(port_out), 32'h0CBA);

        $display("[TB] producer held off while full");
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 4'hD, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'hD, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'hD, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b0);

        $display("[TB] flush mid-frame");
        applyStimulus(1'b0, 1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h2, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h3, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h4, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h5, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h6, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("flush_frame_654", 32'(port_out), 32'h0654);

        $display("[TB] reset while full");
        applyStimulus(1'b1, 1'b1, 4'hE, 1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1, 4'h7, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h8, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
        idleCycles(3);
        checkOutput("reset_frame_987", 32'(port_out), 32'h0987);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);

        $display("[TB] random traffic");
        for (int i = 0; i < 800; i++) begin
            applyStimulus(($urandom_range(0, 149) == 0),
                          ($urandom_range(0, 3) != 0),
                          UNIT_WIDTH'($urandom),
                          ($urandom_range(0, 29) == 0),
                          ($urandom_range(0, 2) == 0));
        end
        idleCycles(3);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
